// File: rtl/texture_spi_loader.sv
// SPI-flash texture loader: reads 2x64x64 texel bytes and streams them as texture-memory writes.
// Optional build macro TEXLOAD_FASTREAD_EN selects the 0x0B fast-read command with 8 dummy bits.
module texture_spi_loader #(
   parameter int          CHANNEL_BITS = 2,
   parameter logic [23:0] FLASH_BASE   = 24'h000000
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      spi_csb,
   output logic                      spi_sclk,
   output logic                      spi_mosi,
   input  logic                      spi_miso,
   output logic                      wr_en,
   output logic                      wr_side,
   output logic [5:0]                wr_col,
   output logic [5:0]                wr_row,
   output logic [CHANNEL_BITS*3-1:0] wr_data
);
   localparam int DW = CHANNEL_BITS * 3;
`ifdef TEXLOAD_FASTREAD_EN
   localparam int                    CMD_BITS = 40;
   localparam logic [CMD_BITS-1:0]   CMD_WORD = {8'h0B, FLASH_BASE, 8'h00};
`else
   localparam int                    CMD_BITS = 32;
   localparam logic [CMD_BITS-1:0]   CMD_WORD = {8'h03, FLASH_BASE};
`endif

   typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

   state_t              state_q, state_d;
   logic                ph_q, ph_d;
   logic [5:0]          bit_cnt_q, bit_cnt_d;
   logic [12:0]         idx_q, idx_d;
   logic [CMD_BITS-1:0] cmd_sr_q, cmd_sr_d;
   logic [DW-2:0]       sh_q, sh_d;
   logic                fin_q, fin_d;
   logic                busy_q, busy_d, done_q, done_d;
   logic                csb_q, csb_d, sclk_q, sclk_d, mosi_q, mosi_d;
   logic                wr_en_q, wr_en_d, wr_side_q, wr_side_d;
   logic [5:0]          wr_col_q, wr_col_d, wr_row_q, wr_row_d;
   logic [DW-1:0]       wr_data_q, wr_data_d, byte_lo;

   // Only the low DW bits of each byte are kept; the shifter is one bit short of that
   // because the final bit comes straight from miso on the sampling edge.
   assign byte_lo = {sh_q, spi_miso};

   always_comb begin
      state_d   = state_q;
      ph_d      = ph_q;
      bit_cnt_d = bit_cnt_q;
      idx_d     = idx_q;
      cmd_sr_d  = cmd_sr_q;
      sh_d      = sh_q;
      fin_d     = fin_q;
      busy_d    = busy_q;
      done_d    = done_q;
      csb_d     = csb_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      wr_en_d   = 1'b0;
      wr_side_d = wr_side_q;
      wr_col_d  = wr_col_q;
      wr_row_d  = wr_row_q;
      wr_data_d = wr_data_q;
      case (state_q)
         IDLE: if (start) begin
            state_d   = CMD;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            csb_d     = 1'b0;
            sclk_d    = 1'b0;
            ph_d      = 1'b0;
            bit_cnt_d = 6'd0;
            idx_d     = 13'd0;
            fin_d     = 1'b0;
            mosi_d    = CMD_WORD[CMD_BITS-1];
            cmd_sr_d  = {CMD_WORD[CMD_BITS-2:0], 1'b0};
         end
         CMD: begin
            ph_d   = ~ph_q;
            sclk_d = ~ph_q;
            if (ph_q) begin
               if (bit_cnt_q == 6'(CMD_BITS - 1)) begin
                  state_d   = DATA;
                  mosi_d    = 1'b0;
                  bit_cnt_d = 6'd0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  mosi_d    = cmd_sr_q[CMD_BITS-1];
                  cmd_sr_d  = {cmd_sr_q[CMD_BITS-2:0], 1'b0};
               end
            end
         end
         DATA: begin
            if (fin_q) begin
               state_d = DONE;
               csb_d   = 1'b1;
               sclk_d  = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               ph_d   = ~ph_q;
               sclk_d = ~ph_q;
               if (ph_q) begin
                  sh_d = byte_lo[DW-2:0];
                  if (bit_cnt_q == 6'd7) begin
                     bit_cnt_d = 6'd0;
                     wr_en_d   = 1'b1;
                     wr_data_d = byte_lo;
                     {wr_side_d, wr_col_d, wr_row_d} = idx_q;
                     // Last texel: hold the index rather than wrapping to 0.
                     if (idx_q == 13'h1FFF) fin_d = 1'b1;
                     else                   idx_d = idx_q + 13'd1;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 6'd1;
                  end
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         ph_q      <= 1'b0;
         bit_cnt_q <= 6'd0;
         idx_q     <= 13'd0;
         cmd_sr_q  <= '0;
         sh_q      <= '0;
         fin_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         csb_q     <= 1'b1;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_side_q <= 1'b0;
         wr_col_q  <= 6'd0;
         wr_row_q  <= 6'd0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         ph_q      <= ph_d;
         bit_cnt_q <= bit_cnt_d;
         idx_q     <= idx_d;
         cmd_sr_q  <= cmd_sr_d;
         sh_q      <= sh_d;
         fin_q     <= fin_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         csb_q     <= csb_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         wr_en_q   <= wr_en_d;
         wr_side_q <= wr_side_d;
         wr_col_q  <= wr_col_d;
         wr_row_q  <= wr_row_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign spi_csb  = csb_q;
   assign spi_sclk = sclk_q;
   assign spi_mosi = mosi_q;
   assign wr_en    = wr_en_q;
   assign wr_side  = wr_side_q;
   assign wr_col   = wr_col_q;
   assign wr_row   = wr_row_q;
   assign wr_data  = wr_data_q;
endmodule

// File: tb/tb_texture_spi_loader.sv
// Bench for texture_spi_loader: SPI flash model, cycle-timeline reference model, directed sequence.
module tb_texture_spi_loader;
`ifdef TEXLOAD_FASTREAD_EN
   localparam int          CB      = 40;
   localparam logic [63:0] EXP_CMD = 64'h0000_000B_1234_5600;
`else
   localparam int          CB      = 32;
   localparam logic [63:0] EXP_CMD = 64'h0000_0000_0312_3456;
`endif
   localparam int T0   = 2 * CB + 16;       // cycle of first write after accept
   localparam int LAST = T0 + 16 * 8191;    // cycle of last write

   logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, spi_miso = 1'b0;
   logic busy, done, spi_csb, spi_sclk, spi_mosi, wr_en, wr_side;
   logic [5:0] wr_col, wr_row, wr_data;

   texture_spi_loader #(.CHANNEL_BITS(2), .FLASH_BASE(24'h123456)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
      .spi_csb(spi_csb), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
      .wr_en(wr_en), .wr_side(wr_side), .wr_col(wr_col), .wr_row(wr_row), .wr_data(wr_data));

   always #5 clk = ~clk;

   int checks = 0, failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] fbyte(input int n);
      logic [12:0] nn;
      nn = n[12:0];
      return nn[7:0] ^ 8'hC0;
   endfunction

   // Flash model plus observation of the DUT's SPI and write traffic.
   int          rcnt = 0, npulse = 0, cs_t = 0, first_t = -1, second_t = -1;
   logic        prev_sclk = 1'b0;
   logic [63:0] cap = '0;
   logic [12:0] obs_addr [0:8191];
   logic [5:0]  obs_data [0:8191];
   always @(negedge clk) begin
      int d;
      logic [7:0] b;
      if (!reset_n) npulse = 0;
      if (spi_csb) begin
         rcnt = 0; cap = '0; cs_t = 0;
      end else begin
         if (spi_sclk && !prev_sclk) begin
            if (rcnt < CB) cap = {cap[62:0], spi_mosi};
            rcnt++;
         end
         if (wr_en) begin
            if (npulse == 0) first_t = cs_t;
            if (npulse == 1) second_t = cs_t;
            if (npulse < 8192) begin
               obs_addr[npulse] = {wr_side, wr_col, wr_row};
               obs_data[npulse] = wr_data;
            end
            npulse++;
         end
         cs_t++;
      end
      prev_sclk = spi_sclk;
      if (rcnt > CB) begin
         d = rcnt - CB - 1;
         b = fbyte(d / 8);
         spi_miso = b[7 - d % 8];
      end else spi_miso = 1'b0;
   end

   // Reference model: position of the DUT on the load timeline.
   bit m_act = 0, m_done = 0, m_dc = 0;
   int m_t = 0;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_act = 0; m_done = 0; m_dc = 0; m_t = 0;
      end else if (m_act) begin
         if (m_t == LAST) begin
            m_act = 0; m_dc = 1; m_done = 1;
         end else m_t++;
      end else if (m_dc) m_dc = 0;
      else if (start) begin
         m_act = 1; m_t = 0; m_done = 0;
      end
   end

   logic [63:0] cmd_v = EXP_CMD;
   logic [12:0] last_addr = '0;
   logic [5:0]  last_data = '0;
   always @(negedge clk) begin
      logic e_mosi, e_wr;
      logic [7:0] b;
      int k;
      e_mosi = (m_act && m_t < 2 * CB) ? cmd_v[CB - 1 - m_t / 2] : 1'b0;
      e_wr   = m_act && m_t >= T0 && ((m_t - T0) % 16 == 0);
      if (!reset_n) begin
         last_addr = '0; last_data = '0;
      end else if (e_wr) begin
         k = (m_t - T0) / 16;
         b = fbyte(k);
         last_addr = k[12:0];
         last_data = b[5:0];
      end
      chk("ctrl{busy,done,csb,sclk,mosi,wr_en}",
          {58'd0, busy, done, spi_csb, spi_sclk, spi_mosi, wr_en},
          {58'd0, m_act, m_done, ~m_act, (m_act && (m_t % 2 == 1)), e_mosi, e_wr});
      chk("wr_addr_data", {45'd0, wr_side, wr_col, wr_row, wr_data}, {45'd0, last_addr, last_data});
   end

   task automatic cyc();
      @(posedge clk); #2;
   endtask

   task automatic wait_pulses(input int target, input int budget);
      int n = 0;
      while (npulse < target && n < budget) begin
         @(posedge clk); n++;
      end
      #2;
      if (npulse < target) chk("wait_pulses_timeout", 64'(npulse), 64'(target));
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b1;
      repeat (5) cyc();
      chk("reset_state{csb,sclk,busy,done,wr_en}",
          {59'd0, spi_csb, spi_sclk, busy, done, wr_en}, 64'b10000);
      reset_n = 1'b1;
      cyc();
      start = 1'b0;
      wait_pulses(1, 400);
      chk("cmd_bits", cap, EXP_CMD);
      chk("first_write_cycle", 64'(first_t), 64'(T0));
      wait_pulses(101, 4000);
      start = 1'b1; cyc(); start = 1'b0;
      chk("busy_after_ignored_start", {63'd0, busy}, 64'd1);
      wait_pulses(2001, 40000);
      reset_n = 1'b0;
      #1;
      chk("midload_reset{csb,wr_en}", {62'd0, spi_csb, wr_en}, 64'b10);
      start = 1'b1;
      repeat (3) cyc();
      reset_n = 1'b1;
      cyc();
      start = 1'b0;
      wait_pulses(1, 400);
      chk("reload_cmd_bits", cap, EXP_CMD);
      chk("reload_first_write_cycle", 64'(first_t), 64'(T0));
      chk("reload_first_addr", {51'd0, obs_addr[0]}, 64'h0000);
      wait_pulses(8192, 140000);
      chk("write_spacing", 64'(second_t - first_t), 64'd16);
      chk("addr_n63",   {51'd0, obs_addr[63]},   {51'd0, 1'b0, 6'd0,  6'd63});
      chk("addr_n64",   {51'd0, obs_addr[64]},   {51'd0, 1'b0, 6'd1,  6'd0});
      chk("addr_n4095", {51'd0, obs_addr[4095]}, {51'd0, 1'b0, 6'd63, 6'd63});
      chk("addr_n4096", {51'd0, obs_addr[4096]}, {51'd0, 1'b1, 6'd0,  6'd0});
      chk("addr_n8191", {51'd0, obs_addr[8191]}, {51'd0, 1'b1, 6'd63, 6'd63});
      chk("data_n5",    {58'd0, obs_data[5]},    64'h05);
      chk("data_n200",  {58'd0, obs_data[200]},  64'h08);
      repeat (40) cyc();
      chk("total_writes", 64'(npulse), 64'd8192);
      chk("final{csb,busy,done}", {61'd0, spi_csb, busy, done}, 64'b101);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/texture_spi_loader.md
Name: texture_spi_loader

Overview:
- Upstream fill stage for the wall texture memory. On a start request it reads the complete texture set (2 sides x 64 columns x 64 rows, one byte per texel) from an external SPI flash.
- Each texel is presented as a one-cycle write to the texture memory, which later serves the {side,col,row} lookups made by the wall renderer.
- Replaces sim-side population of texture memory, so FPGA/ASIC builds behave the same as simulation.

Parameters:
- CHANNEL_BITS, 2, bits per colour channel; texel write width is CHANNEL_BITS*3.
- FLASH_BASE, 24'h000000, flash byte address of texel 0.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  level/pulse; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until DONE.
- done  output  1  high after a complete load; cleared by the next accepted start or by reset.
- spi_csb  output  1  flash chip select, active low.
- spi_sclk  output  1  SPI clock, mode 0.
- spi_mosi  output  1  SPI data to flash.
- spi_miso  input  1  SPI data from flash.
- wr_en  output  1  one-cycle texel write strobe.
- wr_side  output  1  texel side.
- wr_col  output  6  texel column.
- wr_row  output  6  texel row.
- wr_data  output  CHANNEL_BITS*3  texel value.

Behaviour:
- Reset, asynchronous, active-low. While reset_n=0:
  - state=IDLE; busy=0, done=0, spi_csb=1, spi_sclk=0, spi_mosi=0, wr_en=0.
  - wr_side/wr_col/wr_row/wr_data=0.
  - Asserting reset mid-load aborts the load immediately. CSB rises asynchronously and no further writes occur.
- States: IDLE -> CMD -> DATA -> DONE. DONE returns to IDLE in the next cycle with done=1 held.
- IDLE: start=1 on a rising clk edge moves to CMD and clears done. start is ignored in all other states.
- SPI bit timing:
  - Each SPI bit takes exactly 2 clk cycles: sclk low phase, then high phase. SCLK = clk/2.
  - mosi is updated in the cycle sclk goes low.
  - miso is sampled on the clk edge that ends the sclk-high phase.
- CMD:
  - spi_csb=0 on entry.
  - Shift out 32 bits MSB first: 8'h03 then FLASH_BASE[23:0].
  - Duration: 64 clk.
- DATA:
  - Shift in 8192 bytes MSB first. Each byte takes 16 clk.
  - Texel index n (13 bits, 0..8191) maps as {side,col,row} = n: row is the fastest-changing field, side is the slowest.
  - The cycle after byte n's 8th bit is sampled: wr_en=1 for exactly one cycle, wr_data = byte[CHANNEL_BITS*3-1:0], address = n. Upper byte bits are discarded.
  - SCLK keeps running across byte boundaries with no gap, so writes are spaced exactly 16 clk apart.
  - After byte 8191 is written, the next cycle sets spi_csb=1 and sclk=0 and enters DONE.
- DONE: busy=0, done=1. CSB stays high for at least 1 clk before any new start can restart CMD.
- Total load time: (64 + 8192*16) clk from start to the last wr_en, ±2 cycles of pipeline.
- Index counter: 13 bits, must not wrap. A 8192nd write terminates the load; no write to index 0 follows.
- wr_side/col/row/data hold their last values between strobes; only wr_en qualifies them.

Optional Feature:
- Macro: TEXLOAD_FASTREAD_EN.
- Defined:
  - CMD sends 8'h0B, 24-bit address, then 8 dummy bits (mosi=0), for 40 bits / 80 clk.
  - DATA is unchanged.
- Undefined: plain 8'h03 read, 32 bits, no dummy cycles.
- Everything else is identical in both builds.

Test Plan:
- Reset defaults: hold reset_n=0 with start=1 -> csb=1, sclk=0, busy=0, done=0, wr_en=0. No state change until release.
- Command framing: start after reset, FLASH_BASE=24'h123456 -> MOSI bits captured on sclk rising edges are 0x03,0x12,0x34,0x56. csb is low throughout. 64 clk precede the first data bit.
- Data mapping: flash model returns byte = n[7:0] ^ 8'hC0 -> writes at n=0, 63, 64, 4095, 4096, 8191 land at {side,col,row} = {0,0,0}, {0,0,63}, {0,1,0}, {0,63,63}, {1,0,0}, {1,63,63}. wr_data at n=5 is 6'h05 (upper bits dropped). Writes are exactly 16 clk apart; 8192 wr_en pulses total.
- Completion and start-ignore: pulse start at n=100 -> no restart. After the last write, csb rises, done=1, busy=0, and no 8193rd wr_en occurs.
- Reset mid-load: drop reset_n at n=2000 -> csb=1 within the same cycle, wr_en=0. After release with start=1, the reload begins at n=0 with a fresh 0x03 command.
- Fast-read build (TEXLOAD_FASTREAD_EN): MOSI shows 0x0B, address, then 8 zero bits. The first data bit is sampled after 80 clk. The texel mapping matches the standard build.
